// File: rtl/core_sequencer_if.sv
// Shared memory-port handshake between the sequencer and the memory arbiter.
// The sequencer is the master: it holds req/we/addr_sel steady until mem_ready.
interface core_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer for the single-issue RV32 datapath.
// One memory port is shared between instruction fetch and load/store; the
// decoder flags steer EXEC/MEM/WB, ECALL halts, illegal ops and memory
// timeouts park the core in ERROR until reset.
module core_sequencer #(
    parameter int unsigned WORD        = 32,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               dec_regWrite,
    input  logic               dec_memWrite,
    input  logic               dec_mem2reg,
    input  logic               dec_finish,
    input  logic               dec_illegal,
    core_sequencer_if.master   mem,
    output logic               ir_we,
    output logic               alu_we,
    output logic               rf_we,
    output logic               wb_sel,
    output logic               pc_we,
    output logic               halted,
    output logic               error,
    output logic [2:0]         state,
    output logic [WORD-1:0]    instret,
    output logic [WORD-1:0]    cycles
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] HALT   = 3'd6;
    localparam logic [2:0] ERROR  = 3'd7;

    // Timeout counter only has to reach MEM_TIMEOUT-1.
    localparam int unsigned TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    logic [2:0]    state_q;
    logic [2:0]    state_d;
    logic [TW-1:0] tcnt;
    logic          waiting;
    logic          expired;

    assign state  = state_q;
    assign halted = (state_q == HALT);
    assign error  = (state_q == ERROR);

    // A memory state without mem_ready is a wait cycle; the last allowed one expires.
    assign waiting = ((state_q == FETCH) || (state_q == MEM)) && !mem.mem_ready;
    assign expired = (MEM_TIMEOUT != 0) && waiting && (tcnt == TW'(MEM_TIMEOUT - 1));

    // Next-state and strobe decode; ir_we and the MEM-state pc_we follow mem_ready.
    always_comb begin
        state_d          = state_q;
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        ir_we            = 1'b0;
        alu_we           = 1'b0;
        rf_we            = 1'b0;
        wb_sel           = 1'b0;
        pc_we            = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end else if (expired) begin
                    state_d = ERROR;
                end
            end
            DECODE: begin
                if (dec_illegal)     state_d = ERROR;
                else if (dec_finish) state_d = HALT;
                else                 state_d = EXEC;
            end
            EXEC: begin
                alu_we = 1'b1;
                if (dec_memWrite && dec_mem2reg) begin
                    state_d = ERROR;
                end else if (dec_memWrite || dec_mem2reg) begin
                    state_d = MEM;
                end else if (dec_regWrite) begin
                    state_d = WB;
                end else begin
                    pc_we   = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = dec_memWrite;
                if (mem.mem_ready) begin
                    if (dec_memWrite) begin
                        pc_we   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (expired) begin
                    state_d = ERROR;
                end
            end
            WB: begin
                rf_we   = dec_regWrite;
                wb_sel  = dec_mem2reg;
                pc_we   = 1'b1;
                state_d = FETCH;
            end
            default: ; // HALT and ERROR hold until reset
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Wait counter: runs while waiting, cleared by any non-waiting cycle (hence on entry).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       tcnt <= '0;
        else if (waiting) tcnt <= tcnt + TW'(1);
        else              tcnt <= '0;
    end

    // Performance counters: retirements and active (FETCH..WB) cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret <= '0;
            cycles  <= '0;
        end else begin
            if (pc_we) instret <= instret + WORD'(1);
            if ((state_q >= FETCH) && (state_q <= WB)) cycles <= cycles + WORD'(1);
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: directed instruction streams, a per-cycle expected
// trace built from the sequencing rules, and literal pins at key points.
module tb_core_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_FE   = 3'd1;
    localparam logic [2:0] S_DE   = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WB   = 3'd5;
    localparam logic [2:0] S_HALT = 3'd6;
    localparam logic [2:0] S_ERR  = 3'd7;

    logic clk = 1'b0;
    logic rst_n, start, rst2_n, start2;
    logic dec_regWrite, dec_memWrite, dec_mem2reg, dec_finish, dec_illegal;

    logic        ir_we, alu_we, rf_we, wb_sel, pc_we, halted, error;
    logic [2:0]  state;
    logic [31:0] instret, cycles;

    logic        t_ir_we, t_alu_we, t_rf_we, t_wb_sel, t_pc_we, t_halted, t_error;
    logic [2:0]  t_state;
    logic [31:0] t_instret, t_cycles;

    core_sequencer_if m1 ();
    core_sequencer_if m2 ();

    always #5 clk = ~clk;

    core_sequencer #(.WORD(32), .MEM_TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dec_regWrite(dec_regWrite), .dec_memWrite(dec_memWrite),
        .dec_mem2reg(dec_mem2reg), .dec_finish(dec_finish), .dec_illegal(dec_illegal),
        .mem(m1),
        .ir_we(ir_we), .alu_we(alu_we), .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we),
        .halted(halted), .error(error), .state(state), .instret(instret), .cycles(cycles)
    );

    core_sequencer #(.WORD(32), .MEM_TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst2_n), .start(start2),
        .dec_regWrite(dec_regWrite), .dec_memWrite(dec_memWrite),
        .dec_mem2reg(dec_mem2reg), .dec_finish(dec_finish), .dec_illegal(dec_illegal),
        .mem(m2),
        .ir_we(t_ir_we), .alu_we(t_alu_we), .rf_we(t_rf_we), .wb_sel(t_wb_sel), .pc_we(t_pc_we),
        .halted(t_halted), .error(t_error), .state(t_state), .instret(t_instret), .cycles(t_cycles)
    );

    typedef struct {
        logic [2:0]  st;
        logic        req, we, asel, irwe, aluwe, rfwe, wbsel, pcwe, hlt, err;
        logic [31:0] ir, cy;
        int          n;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        ce;
    int          checks = 0;
    int          errors = 0;
    int          ncyc   = 0;
    logic [31:0] m_instret, m_cycles;
    logic        idle_rdy;
    logic        dec_pend;
    logic [4:0]  nxt_dec;   // {regWrite, memWrite, mem2reg, finish, illegal}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, req);
        end
    endtask

    // Compare process: DUT outputs against the expected trace, once per cycle.
    always @(negedge clk) begin
        #2;
        if (exp_q.size() != 0) begin
            ce = exp_q.pop_front();
            chk($sformatf("state[c%0d]", ce.n),   32'(state),           32'(ce.st));
            chk($sformatf("mem_req[c%0d]", ce.n), 32'(m1.mem_req),      32'(ce.req));
            chk($sformatf("mem_we[c%0d]", ce.n),  32'(m1.mem_we),       32'(ce.we));
            chk($sformatf("addrsel[c%0d]", ce.n), 32'(m1.mem_addr_sel), 32'(ce.asel));
            chk($sformatf("ir_we[c%0d]", ce.n),   32'(ir_we),           32'(ce.irwe));
            chk($sformatf("alu_we[c%0d]", ce.n),  32'(alu_we),          32'(ce.aluwe));
            chk($sformatf("rf_we[c%0d]", ce.n),   32'(rf_we),           32'(ce.rfwe));
            chk($sformatf("wb_sel[c%0d]", ce.n),  32'(wb_sel),          32'(ce.wbsel));
            chk($sformatf("pc_we[c%0d]", ce.n),   32'(pc_we),           32'(ce.pcwe));
            chk($sformatf("halted[c%0d]", ce.n),  32'(halted),          32'(ce.hlt));
            chk($sformatf("error[c%0d]", ce.n),   32'(error),           32'(ce.err));
            chk($sformatf("instret[c%0d]", ce.n), instret,              ce.ir);
            chk($sformatf("cycles[c%0d]", ce.n),  cycles,               ce.cy);
        end
    end

    // One clock cycle: drive inputs at the falling edge, record what the outputs must be.
    task automatic cyc(input logic s, input logic rdy, input logic [2:0] st,
                       input logic req, input logic we, input logic asel, input logic irwe,
                       input logic aluwe, input logic rfwe, input logic wbsel, input logic pcwe);
        exp_t e;
        @(negedge clk);
        start       = s;
        m1.mem_ready = rdy;
        if (dec_pend) begin
            {dec_regWrite, dec_memWrite, dec_mem2reg, dec_finish, dec_illegal} = nxt_dec;
            dec_pend = 1'b0;
        end
        e.st = st; e.req = req; e.we = we; e.asel = asel; e.irwe = irwe;
        e.aluwe = aluwe; e.rfwe = rfwe; e.wbsel = wbsel; e.pcwe = pcwe;
        e.hlt = (st == S_HALT);
        e.err = (st == S_ERR);
        e.ir  = m_instret;
        e.cy  = m_cycles;
        e.n   = ncyc;
        ncyc++;
        exp_q.push_back(e);
        if (st >= S_FE && st <= S_WB) m_cycles++;
        if (pcwe) m_instret++;
    endtask

    task automatic kick();
        cyc(1'b1, idle_rdy, S_IDLE, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // kind: 0 ALU no-rd, 1 ADDI, 2 LW, 3 SW, 4 ECALL, 5 illegal(+finish), 6 load&store both set
    task automatic instr(input int kind, input int fw, input int mw);
        case (kind)
            0:       nxt_dec = 5'b00000;
            1:       nxt_dec = 5'b10000;
            2:       nxt_dec = 5'b10100;
            3:       nxt_dec = 5'b01000;
            4:       nxt_dec = 5'b00010;
            5:       nxt_dec = 5'b00011;
            default: nxt_dec = 5'b01100;
        endcase
        dec_pend = 1'b1;
        for (int i = 0; i < fw; i++) cyc(0, 0, S_FE, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, S_FE, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, idle_rdy, S_DE, 0, 0, 0, 0, 0, 0, 0, 0);
        if (kind == 4 || kind == 5) return;
        case (kind)
            0: cyc(0, idle_rdy, S_EX, 0, 0, 0, 0, 1, 0, 0, 1);
            1: begin
                cyc(0, idle_rdy, S_EX, 0, 0, 0, 0, 1, 0, 0, 0);
                cyc(0, idle_rdy, S_WB, 0, 0, 0, 0, 0, 1, 0, 1);
            end
            2: begin
                cyc(0, idle_rdy, S_EX, 0, 0, 0, 0, 1, 0, 0, 0);
                for (int i = 0; i < mw; i++) cyc(0, 0, S_MEM, 1, 0, 1, 0, 0, 0, 0, 0);
                cyc(0, 1, S_MEM, 1, 0, 1, 0, 0, 0, 0, 0);
                cyc(0, idle_rdy, S_WB, 0, 0, 0, 0, 0, 1, 1, 1);
            end
            3: begin
                cyc(0, idle_rdy, S_EX, 0, 0, 0, 0, 1, 0, 0, 0);
                for (int i = 0; i < mw; i++) cyc(0, 0, S_MEM, 1, 1, 1, 0, 0, 0, 0, 0);
                cyc(0, 1, S_MEM, 1, 1, 1, 0, 0, 0, 0, 1);
            end
            default: cyc(0, idle_rdy, S_EX, 0, 0, 0, 0, 1, 0, 0, 0);
        endcase
    endtask

    task automatic rst_seq();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        m1.mem_ready = 1'b0;
        m_instret = '0;
        m_cycles  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0; start2 = 1'b0;
        m1.mem_ready = 1'b0; m2.mem_ready = 1'b0;
        {dec_regWrite, dec_memWrite, dec_mem2reg, dec_finish, dec_illegal} = '0;
        m_instret = '0; m_cycles = '0; idle_rdy = 1'b0; dec_pend = 1'b0; nxt_dec = '0;

        // Reset state.
        @(negedge clk); #2;
        chk("rst_state",   32'(state),      32'd0);
        chk("rst_mem_req", 32'(m1.mem_req), 32'd0);
        chk("rst_instret", instret,         32'd0);
        chk("rst_cycles",  cycles,          32'd0);
        @(negedge clk); rst_n = 1'b1;

        // ADDI with mem_ready permanently high: 1,2,3,5 then back to FETCH.
        idle_rdy = 1'b1;
        kick();
        instr(1, 0, 0);
        @(posedge clk); #1;
        chk("addi_instret", instret,     32'd1);
        chk("addi_cycles",  cycles,      32'd4);
        chk("addi_state",   32'(state),  32'(S_FE));

        // LW with slow fetch and 3 MEM waits, SW, then an ALU op with no rd.
        idle_rdy = 1'b0;
        instr(2, 2, 3);
        instr(3, 0, 1);
        instr(0, 1, 0);

        // Two ADDIs then ECALL; start pulses in HALT change nothing.
        rst_seq();
        kick();
        instr(1, 0, 0);
        instr(1, 0, 0);
        instr(4, 0, 0);
        for (int i = 0; i < 3; i++) cyc(logic'(i % 2 == 0), 0, S_HALT, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("ecall_halted",  32'(halted), 32'd1);
        chk("ecall_instret", instret,     32'd2);

        // Illegal wins over finish in DECODE.
        rst_seq();
        kick();
        instr(5, 0, 0);
        for (int i = 0; i < 2; i++) cyc(1, 1, S_ERR, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("illegal_error", 32'(error), 32'd1);
        chk("illegal_state", 32'(state), 32'(S_ERR));

        // Load and store flagged together is rejected after EXEC.
        rst_seq();
        kick();
        instr(6, 0, 0);
        for (int i = 0; i < 2; i++) cyc(0, 0, S_ERR, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset asserted mid-MEM, then restart with a ready-already fetch.
        rst_seq();
        kick();
        nxt_dec  = 5'b10100;
        dec_pend = 1'b1;
        cyc(0, 1, S_FE, 1, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, S_DE, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, S_EX, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, S_MEM, 1, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, S_MEM, 1, 0, 1, 0, 0, 0, 0, 0);
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", 32'(m1.mem_req), 32'd0);
        chk("midrst_state",   32'(state),      32'd0);
        chk("midrst_instret", instret,         32'd0);
        chk("midrst_cycles",  cycles,          32'd0);
        m_instret = '0;
        m_cycles  = '0;
        @(negedge clk); rst_n = 1'b1;
        idle_rdy = 1'b1;
        kick();
        instr(1, 0, 0);
        @(posedge clk); #1;
        chk("restart_instret", instret, 32'd1);
        chk("restart_cycles",  cycles,  32'd4);

        // Timeout instance (MEM_TIMEOUT=4): four FETCH waits, then ERROR with mem_req low.
        @(negedge clk);
        rst2_n = 1'b1;
        start2 = 1'b1;
        m2.mem_ready = 1'b0;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("to_state[%0d]", i),   32'(t_state),     32'(S_FE));
            chk($sformatf("to_mem_req[%0d]", i), 32'(m2.mem_req),  32'd1);
            chk($sformatf("to_ir_we[%0d]", i),   32'(t_ir_we),     32'd0);
            @(negedge clk);
        end
        #2;
        chk("to_err_state",   32'(t_state),    32'(S_ERR));
        chk("to_err_mem_req", 32'(m2.mem_req), 32'd0);
        chk("to_err_flag",    32'(t_error),    32'd1);
        chk("to_cycles",      t_cycles,        32'd4);
        @(negedge clk);
        m2.mem_ready = 1'b1;
        start2 = 1'b1;
        #2;
        chk("to_err_sticky", 32'(t_state), 32'(S_ERR));
        chk("to_err_pc_we",  32'({t_pc_we, t_alu_we, t_rf_we, t_wb_sel, t_halted}), 32'd0);
        chk("to_instret",    t_instret, 32'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
